id_ex_register: RTL
===================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: stall_e  input  1  hold E-side contents this cycle.
REQ-004 SHALL have port: flush_e  input  1  replace E-side contents with a bubble this cycle.
REQ-005 SHALL have port: valid_d  input  1  D-side holds a real instruction.
REQ-006 SHALL have ports: RegWriteD, MemWriteD, BranchD, JumpD  input  1 each  decode control bits.
REQ-007 SHALL have ports: ALUSrcD  input  alu_src_b_t; ResultSrcD  input  result_src_t; ALUOpD  input  3  decode control fields.
REQ-008 SHALL have ports: funct3D  input  3; funct7b5D  input  1  ALU decoder / branch inputs.
REQ-009 SHALL have ports: RD1D, RD2D, PCD, PCPlus4D, ImmExtD  input  32 each  operands and PC values.
REQ-010 SHALL have ports: Rs1D, Rs2D, RdD  input  5 each  register indices for hazard/forwarding.
REQ-011 SHALL have one output per D-side input above, suffix E, same width/type (RegWriteE ... RdE), plus valid_e  output  1.
REQ-012 SHALL have port: bubble_count  output  16  count of bubbles entering E.

Function
REQ-013 SHALL update all E-side registers once per rising clk edge per REQ-014..REQ-017, priority flush_e > stall_e > load.
REQ-014 flush_e=1: SHALL clear valid_e, RegWriteE, MemWriteE, BranchE, JumpE, ALUOpE, ALUSrcE, ResultSrcE, all data/index outputs to 0, regardless of stall_e.
REQ-015 flush_e=0, stall_e=1: SHALL hold every E-side output, valid_e, and bubble_count unchanged.
REQ-016 flush_e=0, stall_e=0, valid_d=1: SHALL capture every D-side input into its E output; valid_e <= 1.
REQ-017 flush_e=0, stall_e=0, valid_d=0: SHALL load a bubble (identical to REQ-014 values).
REQ-018 Latency SHALL be exactly 1 cycle D -> E; no combinational path from any input to any output.
REQ-019 A bubble (valid_e=0) SHALL always present RegWriteE=0, MemWriteE=0, BranchE=0, JumpE=0, so no architectural side effect downstream.
REQ-020 bubble_count SHALL increment by 1 on each edge where REQ-014 or REQ-017 applies, and not otherwise.
REQ-021 bubble_count SHALL saturate at 16'hFFFF (no wrap to 0).
REQ-022 stall_e held N cycles SHALL keep outputs stable all N cycles; first edge after release SHALL take the then-current D inputs (held D values are not replayed).
REQ-023 Simultaneous flush_e=1 and stall_e=1 SHALL act as flush only and SHALL count one bubble.
REQ-024 X/Z on D-side inputs while valid_d=0 or flush_e=1 SHALL NOT propagate to any E output.

Reset
REQ-025 reset=0 SHALL immediately (without clk) force all E outputs, valid_e, and bubble_count to 0.
REQ-026 reset asserted mid-stall or mid-flush SHALL override both; first edge after reset release SHALL follow REQ-013 normally.
REQ-027 reset SHALL NOT count as a bubble.

Verification
REQ-028 reset=0 pulse between edges with E holding RdE=5'd7, valid_e=1 -> all outputs 0 immediately, bubble_count=0.
REQ-029 valid_d=1, RD1D=32'hDEADBEEF, RdD=5'd10, RegWriteD=1, one edge -> RD1E=32'hDEADBEEF, RdE=10, RegWriteE=1, valid_e=1; bubble_count unchanged.
REQ-030 Load as REQ-029, then stall_e=1 three edges with RD1D=32'h0 -> RD1E stays 32'hDEADBEEF; release -> RD1E=32'h0.
REQ-031 flush_e=1 and stall_e=1 together with valid_d=1, MemWriteD=1 -> MemWriteE=0, valid_e=0, bubble_count +1.
REQ-032 valid_d=0 with RegWriteD=1, ImmExtD=32'h1234 for 4 edges -> RegWriteE=0, ImmExtE=0, bubble_count +4.
REQ-033 bubble_count preloaded to 16'hFFFE via 2 extra bubbles pending -> after 3 bubble edges bubble_count=16'hFFFF, stays there.

Source files
------------

// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - shared ID/EX control encodings and the D/E-side bus interface

package id_ex_pkg;

  // Second ALU operand select
  typedef enum logic [1:0] {
    ALU_SRC_B_REG = 2'd0,
    ALU_SRC_B_IMM = 2'd1,
    ALU_SRC_B_PC  = 2'd2
  } alu_src_b_t;

  // Writeback result select
  typedef enum logic [1:0] {
    RESULT_SRC_ALU  = 2'd0,
    RESULT_SRC_MEM  = 2'd1,
    RESULT_SRC_PC4  = 2'd2,
    RESULT_SRC_IMM  = 2'd3
  } result_src_t;

endpackage

interface id_ex_register_if;

  // Pipeline control
  logic                    stall_e;
  logic                    flush_e;
  logic                    valid_d;

  // Decode-side inputs
  logic                    RegWriteD;
  logic                    MemWriteD;
  logic                    BranchD;
  logic                    JumpD;
  id_ex_pkg::alu_src_b_t   ALUSrcD;
  id_ex_pkg::result_src_t  ResultSrcD;
  logic [2:0]              ALUOpD;
  logic [2:0]              funct3D;
  logic                    funct7b5D;
  logic [31:0]             RD1D;
  logic [31:0]             RD2D;
  logic [31:0]             PCD;
  logic [31:0]             PCPlus4D;
  logic [31:0]             ImmExtD;
  logic [4:0]              Rs1D;
  logic [4:0]              Rs2D;
  logic [4:0]              RdD;

  // Execute-side outputs
  logic                    RegWriteE;
  logic                    MemWriteE;
  logic                    BranchE;
  logic                    JumpE;
  id_ex_pkg::alu_src_b_t   ALUSrcE;
  id_ex_pkg::result_src_t  ResultSrcE;
  logic [2:0]              ALUOpE;
  logic [2:0]              funct3E;
  logic                    funct7b5E;
  logic [31:0]             RD1E;
  logic [31:0]             RD2E;
  logic [31:0]             PCE;
  logic [31:0]             PCPlus4E;
  logic [31:0]             ImmExtE;
  logic [4:0]              Rs1E;
  logic [4:0]              Rs2E;
  logic [4:0]              RdE;
  logic                    valid_e;
  logic [15:0]             bubble_count;

  // Decode stage / hazard unit side
  modport master (
    output stall_e, flush_e, valid_d,
    output RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUOpD,
    output funct3D, funct7b5D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUOpE,
    input  funct3E, funct7b5E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
    input  valid_e, bubble_count
  );

  // Pipeline register side
  modport slave (
    input  stall_e, flush_e, valid_d,
    input  RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUOpD,
    input  funct3D, funct7b5D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUOpE,
    output funct3E, funct7b5E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
    output valid_e, bubble_count
  );

endinterface

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with flush/stall priority and saturating bubble counter

module id_ex_register
  import id_ex_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  id_ex_register_if.slave bus
);

  localparam logic [15:0] CountMax = 16'hFFFF;

  // A bubble enters E on flush (even while stalled) or when an unstalled D side has nothing valid.
  logic insertBubble;
  logic loadD;

  assign insertBubble = bus.flush_e | (~bus.stall_e & ~bus.valid_d);
  assign loadD        = ~bus.flush_e & ~bus.stall_e & bus.valid_d;

  // E-side state: bubble clears to constants so D-side garbage never leaks; stall holds everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid_e    <= 1'b0;
      bus.RegWriteE  <= 1'b0;
      bus.MemWriteE  <= 1'b0;
      bus.BranchE    <= 1'b0;
      bus.JumpE      <= 1'b0;
      bus.ALUSrcE    <= ALU_SRC_B_REG;
      bus.ResultSrcE <= RESULT_SRC_ALU;
      bus.ALUOpE     <= 3'd0;
      bus.funct3E    <= 3'd0;
      bus.funct7b5E  <= 1'b0;
      bus.RD1E       <= 32'd0;
      bus.RD2E       <= 32'd0;
      bus.PCE        <= 32'd0;
      bus.PCPlus4E   <= 32'd0;
      bus.ImmExtE    <= 32'd0;
      bus.Rs1E       <= 5'd0;
      bus.Rs2E       <= 5'd0;
      bus.RdE        <= 5'd0;
    end else if (insertBubble) begin
      bus.valid_e    <= 1'b0;
      bus.RegWriteE  <= 1'b0;
      bus.MemWriteE  <= 1'b0;
      bus.BranchE    <= 1'b0;
      bus.JumpE      <= 1'b0;
      bus.ALUSrcE    <= ALU_SRC_B_REG;
      bus.ResultSrcE <= RESULT_SRC_ALU;
      bus.ALUOpE     <= 3'd0;
      bus.funct3E    <= 3'd0;
      bus.funct7b5E  <= 1'b0;
      bus.RD1E       <= 32'd0;
      bus.RD2E       <= 32'd0;
      bus.PCE        <= 32'd0;
      bus.PCPlus4E   <= 32'd0;
      bus.ImmExtE    <= 32'd0;
      bus.Rs1E       <= 5'd0;
      bus.Rs2E       <= 5'd0;
      bus.RdE        <= 5'd0;
    end else if (loadD) begin
      bus.valid_e    <= 1'b1;
      bus.RegWriteE  <= bus.RegWriteD;
      bus.MemWriteE  <= bus.MemWriteD;
      bus.BranchE    <= bus.BranchD;
      bus.JumpE      <= bus.JumpD;
      bus.ALUSrcE    <= bus.ALUSrcD;
      bus.ResultSrcE <= bus.ResultSrcD;
      bus.ALUOpE     <= bus.ALUOpD;
      bus.funct3E    <= bus.funct3D;
      bus.funct7b5E  <= bus.funct7b5D;
      bus.RD1E       <= bus.RD1D;
      bus.RD2E       <= bus.RD2D;
      bus.PCE        <= bus.PCD;
      bus.PCPlus4E   <= bus.PCPlus4D;
      bus.ImmExtE    <= bus.ImmExtD;
      bus.Rs1E       <= bus.Rs1D;
      bus.Rs2E       <= bus.Rs2D;
      bus.RdE        <= bus.RdD;
    end
  end

  // Bubble counter: one per bubble edge, pinned at all-ones instead of wrapping; reset is not a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.bubble_count <= 16'd0;
    end else if (insertBubble && (bus.bubble_count != CountMax)) begin
      bus.bubble_count <= bus.bubble_count + 16'd1;
    end
  end

endmodule
